addsub_seq: RTL
===============

# addsub_seq

Multi-byte adder/subtractor sequencer. Accepts one BYTES-wide add or subtract request and runs it least-significant byte first through a single internal 8-bit add/sub datapath, one byte per clock, with the carry registered between bytes. It sits between the ALU's operation decode and the 8-bit adder/subtractor so that wide arithmetic reuses the one byte-wide datapath instead of replicating it.

## Interface
Parameters:
- BYTES, 4: operand width in bytes; legal range 1..16; word width W = 8*BYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
- a  input  W  first operand; sampled with start.
- b  input  W  second operand; sampled with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle completion pulse.
- result  output  W  final sum/difference; held until the next completion.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

## Operation
- Datapath per byte i: sum_i = a[i] + (b[i] XOR {8{sub}}) + c_i, where c_0 = sub and c_(i+1) = carry out of byte i. This is two's-complement subtraction via invert-and-add-one.
- Operands, sub, and the internal byte index are latched on accept. Later changes to a, b, or sub have no effect on the running operation.
- Partial sums go to an internal shadow register. result, cout, ovf, and zero update together, only on the transition RUN->DONE.
- ovf = (a_msb == bx_msb) && (res_msb != a_msb), with bx = b XOR {W{sub}}.
- zero = (final W-bit result == 0); it ignores cout.
- State machine, encoded as 2-bit IDLE/RUN/DONE:
  - IDLE: if start, latch inputs, set idx=0 and carry=sub, go to RUN. Otherwise stay in IDLE.
  - RUN: process byte idx and register its carry. If idx == BYTES-1, commit the outputs and go to DONE. Otherwise increment idx and stay in RUN.
  - DONE: done=1 for this cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. A start held high through DONE is accepted in the following IDLE cycle.
- BYTES=1: RUN lasts exactly one cycle.
- idx wraps nowhere: it never exceeds BYTES-1.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, zero=0. The shadow register, idx, and carry are cleared.
- Reset mid-RUN or in DONE: the in-flight operation is discarded and no done pulse is produced. After deassertion, the first rising edge with start=1 is accepted normally.
- Cycle timeline, with start sampled high in IDLE at edge E0:
  - busy=1 from E0 until edge E(BYTES).
  - done=1 from E(BYTES) until E(BYTES+1).
  - result and flags are valid from E(BYTES) onward.
- Latency: start edge to done = BYTES cycles.
- Issue interval: BYTES+2 cycles minimum between accepted starts (with start held high).
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All cases use BYTES=4 unless stated.

1. Add 0x000000FF + 0x00000001 -> result 0x00000100, cout=0, ovf=0, zero=0. done rises exactly 4 edges after the start edge; busy is high for exactly 4 cycles.
2. Sub 0x00000005 - 0x00000005 -> result 0x00000000, cout=1, zero=1, ovf=0.
3. Sub 0x00000003 - 0x00000005 -> result 0xFFFFFFFE, cout=0 (borrow), ovf=0.
4. Overflow and carry cases:
   - Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, ovf=1, cout=0.
   - Add 0xFFFFFFFF + 0x00000001 -> 0x00000000, cout=1, zero=1, ovf=0.
   - Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf=1, cout=1.
5. Start Add 0x11111111 + 0x22222222. Then, during RUN, pulse start and change a, b, and sub. Required:
   - result 0x33333333 with a single done pulse.
   - The second start is ignored.
   - result is unchanged (previous value) until the done edge.
6. Assert rst for one cycle midway through RUN, in byte 2. Required:
   - All outputs go to 0 without waiting for a clock edge.
   - No done pulse follows.
   - A new Add 0x00000002 + 0x00000003 issued after reset gives result 0x00000005.
   - Repeat case 1 with BYTES=1 (0xFF + 0x01 -> 0x00, cout=1, zero=1, done 1 cycle after start).

Source files
------------

// File: rtl/addsub_seq_if.sv
// Request/response bundle for the multi-byte add/sub sequencer.
// Master drives the operation request; slave returns status and the committed result.
interface addsub_seq_if #(
  parameter int unsigned BYTES = 4
);
  localparam int unsigned W = 8 * BYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-byte adder/subtractor: runs a BYTES-wide add or subtract through one 8-bit
// datapath, least-significant byte first, with the carry registered between bytes.
module addsub_seq #(
  parameter int unsigned BYTES = 4
) (
  input logic         clk,
  input logic         rst,
  addsub_seq_if.slave bus
);
  localparam int unsigned W    = 8 * BYTES;
  localparam int unsigned IdxW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    bx_q, bx_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [7:0]      a_byte;
  logic [7:0]      bx_byte;
  logic [8:0]      byte_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      bx_q     <= '0;
      shadow_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // b is stored pre-inverted for subtract so the byte datapath is always an add.
  always_comb begin
    a_byte   = 8'(a_q >> {idx_q, 3'b000});
    bx_byte  = 8'(bx_q >> {idx_q, 3'b000});
    byte_sum = {1'b0, a_byte} + {1'b0, bx_byte} + {8'b0, carry_q};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    bx_d     = bx_q;
    shadow_d = shadow_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.a;
          bx_d     = bus.b ^ {W{bus.sub}};
          carry_d  = bus.sub;
          idx_d    = '0;
          shadow_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        shadow_d[{idx_q, 3'b000} +: 8] = byte_sum[7:0];
        carry_d                        = byte_sum[8];
        if (idx_q == IdxW'(BYTES - 1)) begin
          // Commit uses the merged shadow so the last byte lands in the same edge.
          result_d = shadow_d;
          cout_d   = byte_sum[8];
          ovf_d    = (a_q[W-1] == bx_q[W-1]) && (shadow_d[W-1] != a_q[W-1]);
          zero_d   = (shadow_d == '0);
          state_d  = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule
